// File: rtl/baud_cfg_if.sv
// Handshake bundle between the register/command side, the UART busy flags
// and the baud generator's select/reset inputs.
interface baud_cfg_if;
    logic       req;
    logic [2:0] req_sel;
    logic       tx_busy;
    logic       rx_busy;
    logic [2:0] select;
    logic       gen_resetn;
    logic       busy;
    logic       rate_valid;
    logic       ack;
    logic       req_drop;

    modport master (
        output req, req_sel, tx_busy, rx_busy,
        input  select, gen_resetn, busy, rate_valid, ack, req_drop
    );

    modport slave (
        input  req, req_sel, tx_busy, rx_busy,
        output select, gen_resetn, busy, rate_valid, ack, req_drop
    );
endinterface

// File: rtl/baud_cfg_ctrl.sv
// Baud-rate reconfiguration controller: waits for the UART to drain, holds the
// baud generator in reset while the new select code is applied, then settles.
module baud_cfg_ctrl #(
    parameter logic [2:0] DEFAULT_SEL   = 3'd3,
    parameter int         HOLD_CYCLES   = 4,
    parameter int         SETTLE_CYCLES = 32
) (
    input  logic      CLK100MHZ,
    input  logic      reset,
    baud_cfg_if.slave cfg
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        HOLD,
        SETTLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    pending, pending_n;
    logic          init, init_n;
    logic [2:0]    select_r, select_n;
    logic          gen_resetn_r, gen_resetn_n;
    logic          busy_r, busy_n;
    logic          rate_valid_r, rate_valid_n;
    logic          ack_r, ack_n;
    logic          req_drop_r, req_drop_n;

    // The init flag only exists to suppress the ack at the end of the
    // post-reset sequence; select is already DEFAULT_SEL from reset.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pending_n  = pending;
        init_n     = init;
        select_n   = select_r;
        ack_n      = 1'b0;
        req_drop_n = 1'b0;

        case (state)
            IDLE: begin
                if (cfg.req) begin
                    pending_n = cfg.req_sel;
                    if (cfg.req_sel == select_r) begin
                        ack_n = 1'b1;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!cfg.tx_busy && !cfg.rx_busy) begin
                    state_n  = HOLD;
                    cnt_n    = HOLD_LOAD;
                    select_n = pending;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = SETTLE;
                    cnt_n   = SETTLE_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    ack_n   = !init;
                    init_n  = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (cfg.req && (state != IDLE)) begin
            req_drop_n = 1'b1;
        end

        // Status outputs are registered copies of the next state's view.
        gen_resetn_n = (state_n != HOLD);
        busy_n       = (state_n != IDLE);
        rate_valid_n = (state_n == IDLE);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state        <= HOLD;
            cnt          <= HOLD_LOAD;
            pending      <= DEFAULT_SEL;
            init         <= 1'b1;
            select_r     <= DEFAULT_SEL;
            gen_resetn_r <= 1'b0;
            busy_r       <= 1'b1;
            rate_valid_r <= 1'b0;
            ack_r        <= 1'b0;
            req_drop_r   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pending      <= pending_n;
            init         <= init_n;
            select_r     <= select_n;
            gen_resetn_r <= gen_resetn_n;
            busy_r       <= busy_n;
            rate_valid_r <= rate_valid_n;
            ack_r        <= ack_n;
            req_drop_r   <= req_drop_n;
        end
    end

    assign cfg.select     = select_r;
    assign cfg.gen_resetn = gen_resetn_r;
    assign cfg.busy       = busy_r;
    assign cfg.rate_valid = rate_valid_r;
    assign cfg.ack        = ack_r;
    assign cfg.req_drop   = req_drop_r;

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Directed bench for baud_cfg_ctrl; observed vector is
// {select[2:0], gen_resetn, busy, rate_valid, ack, req_drop}.
module tb_baud_cfg_ctrl;

    localparam int H = 4;
    localparam int S = 32;

    logic CLK100MHZ = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    baud_cfg_if bif ();

    baud_cfg_ctrl #(
        .DEFAULT_SEL  (3'd3),
        .HOLD_CYCLES  (H),
        .SETTLE_CYCLES(S)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset    (reset),
        .cfg      (bif.slave)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    function automatic logic [7:0] observed();
        return {bif.select, bif.gen_resetn, bif.busy, bif.rate_valid, bif.ack, bif.req_drop};
    endfunction

    function automatic logic [7:0] exp_init(int c);
        if (c < H)          return {3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        else if (c < H + S) return {3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        else                return {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction

    // Expected outputs for a change request sampled in cycle 0 whose HOLD starts at cycle hs.
    function automatic logic [7:0] exp_change(int c, int hs, logic [2:0] old_s, logic [2:0] new_s, logic drop);
        if (c == 0)               return {old_s, 1'b1, 1'b0, 1'b1, 1'b0, drop};
        else if (c < hs)          return {old_s, 1'b1, 1'b1, 1'b0, 1'b0, drop};
        else if (c < hs + H)      return {new_s, 1'b0, 1'b1, 1'b0, 1'b0, drop};
        else if (c < hs + H + S)  return {new_s, 1'b1, 1'b1, 1'b0, 1'b0, drop};
        else if (c == hs + H + S) return {new_s, 1'b1, 1'b0, 1'b1, 1'b1, drop};
        else                      return {new_s, 1'b1, 1'b0, 1'b1, 1'b0, drop};
    endfunction

    task automatic apply_reset();
        bif.req = 1'b0;
        bif.tx_busy = 1'b0;
        bif.rx_busy = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (H + S + 4) tick();
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        reset = 1'b1;
        bif.req = 1'b0;
        bif.req_sel = 3'd0;
        bif.tx_busy = 1'b0;
        bif.rx_busy = 1'b0;
        tick();
        tick();
        exp = {3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_state observed=%b expected=%b", observed(), exp);
        end
        reset = 1'b0;
        for (int c = 0; c < H + S + 4; c++) begin
            exp = exp_init(c);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("[TB] FAIL init_seq c=%0d observed=%b expected=%b", c, observed(), exp);
            end
            tick();
        end
    endtask

    task automatic test_change_idle();
        logic [7:0] exp;
        bif.req = 1'b1;
        bif.req_sel = 3'd7;
        for (int c = 0; c <= 40; c++) begin
            exp = exp_change(c, 2, 3'd3, 3'd7, 1'b0);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("[TB] FAIL change_idle c=%0d observed=%b expected=%b", c, observed(), exp);
            end
            tick();
            bif.req = 1'b0;
            bif.rx_busy = (c + 1 >= 10) && (c + 1 <= 20);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        bif.req = 1'b1;
        bif.req_sel = 3'd7;
        exp = {3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("[TB] FAIL same_sel_c0 observed=%b expected=%b", observed(), exp);
        end
        tick();
        bif.req_sel = 3'd2;
        exp = {3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("[TB] FAIL same_sel_ack observed=%b expected=%b", observed(), exp);
        end
        tick();
        bif.req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            exp = exp_change(c, 2, 3'd7, 3'd2, 1'b0);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("[TB] FAIL back_to_back c=%0d observed=%b expected=%b", c, observed(), exp);
            end
            tick();
        end
    endtask

    task automatic test_drain_wait();
        logic [7:0] exp;
        apply_reset();
        bif.req = 1'b1;
        bif.req_sel = 3'd7;
        bif.tx_busy = 1'b1;
        bif.rx_busy = 1'b1;
        for (int c = 0; c <= 50; c++) begin
            exp = exp_change(c, 11, 3'd3, 3'd7, 1'b0);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("[TB] FAIL drain_wait c=%0d observed=%b expected=%b", c, observed(), exp);
            end
            tick();
            bif.req = 1'b0;
            bif.tx_busy = (c + 1 < 10);
            bif.rx_busy = (c + 1 < 7);
        end
    endtask

    task automatic test_req_drop();
        logic [7:0] exp;
        logic       drop;
        int         n;
        bif.req = 1'b1;
        bif.req_sel = 3'd5;
        bif.tx_busy = 1'b1;
        for (int c = 0; c <= 46; c++) begin
            drop = (c == 4) || (c == 21) || (c == 31) || (c == 32);
            exp = exp_change(c, 7, 3'd7, 3'd5, drop);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("[TB] FAIL req_drop c=%0d observed=%b expected=%b", c, observed(), exp);
            end
            tick();
            n = c + 1;
            bif.tx_busy = (n <= 5) || ((n >= 8) && (n <= 15));
            bif.req = (n == 3) || (n == 20) || (n == 30) || (n == 31);
            bif.req_sel = (n == 3) ? 3'd6 : ((n == 20) ? 3'd1 : 3'd4);
        end
        bif.tx_busy = 1'b0;
        bif.req = 1'b0;
    endtask

    task automatic test_reset_mid_settle();
        logic [7:0] exp;
        apply_reset();
        bif.req = 1'b1;
        bif.req_sel = 3'd5;
        for (int c = 0; c <= 20; c++) begin
            exp = exp_change(c, 2, 3'd3, 3'd5, 1'b0);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("[TB] FAIL pre_reset c=%0d observed=%b expected=%b", c, observed(), exp);
            end
            if (c == 20) reset = 1'b1;
            tick();
            bif.req = 1'b0;
        end
        reset = 1'b0;
        for (int c = 0; c < H + S + 4; c++) begin
            exp = exp_init(c);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("[TB] FAIL reinit c=%0d observed=%b expected=%b", c, observed(), exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_change_idle();
        test_back_to_back();
        test_drain_wait();
        test_req_drop();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
